// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction, PC, link address and fetch exception for decode.
// One-cycle latency, no combinational input-to-output path; Flush inserts a bubble and overrides Stall, which holds.
module if_id_reg #(
    parameter logic [31:0] RESET_PC  = 32'h00003000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] PCIn,
    input  logic [31:0] InstrIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic        IsBranchD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PC8D,
    output logic [4:0]  ExcCodeD,
    output logic        BDD,
    output logic        ValidD
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
        logic        vld;
    } id_stage_t;

    localparam id_stage_t RESET_STAGE = '{
        instr: NOP_INSTR,
        pc:    RESET_PC,
        pc8:   RESET_PC + 32'd8,
        exc:   5'd0,
        bd:    1'b0,
        vld:   1'b0
    };

    id_stage_t   r_stage;
    id_stage_t   w_load;
    id_stage_t   w_bubble;
    logic [31:0] w_pc8;

    // Link address wraps modulo 2^32; no range checking is done here.
    assign w_pc8 = PCIn + 32'd8;

    // A faulting fetch still carries its PC/BD so EPC can be formed, but its word is never decoded.
    always_comb begin
        w_load       = '0;
        w_load.instr = (ExcCodeIn == 5'd0) ? InstrIn : NOP_INSTR;
        w_load.pc    = PCIn;
        w_load.pc8   = w_pc8;
        w_load.exc   = ExcCodeIn;
        w_load.bd    = IsBranchD;
        w_load.vld   = 1'b1;
    end

    always_comb begin
        w_bubble       = '0;
        w_bubble.instr = NOP_INSTR;
        w_bubble.pc    = PCIn;
        w_bubble.pc8   = w_pc8;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= RESET_STAGE;
        end else if (Flush) begin
            r_stage <= w_bubble;
        end else if (!Stall) begin
            r_stage <= w_load;
        end
    end

    assign InstrD   = r_stage.instr;
    assign PCD      = r_stage.pc;
    assign PC8D     = r_stage.pc8;
    assign ExcCodeD = r_stage.exc;
    assign BDD      = r_stage.bd;
    assign ValidD   = r_stage.vld;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed vectors plus random traffic against a behavioural model of the ID stage.
module tb_if_id_reg;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [31:0] PCIn;
    logic [31:0] InstrIn;
    logic [4:0]  ExcCodeIn;
    logic        IsBranchD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PC8D;
    logic [4:0]  ExcCodeD;
    logic        BDD;
    logic        ValidD;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the ID stage should be presenting.
    logic [31:0] m_instr, m_pc, m_pc8;
    logic [4:0]  m_exc;
    logic        m_bd, m_vld;

    if_id_reg #(
        .RESET_PC (32'h00003000),
        .NOP_INSTR(32'h00000000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Stall    (Stall),
        .Flush    (Flush),
        .PCIn     (PCIn),
        .InstrIn  (InstrIn),
        .ExcCodeIn(ExcCodeIn),
        .IsBranchD(IsBranchD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PC8D     (PC8D),
        .ExcCodeD (ExcCodeD),
        .BDD      (BDD),
        .ValidD   (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".InstrD"},   InstrD,          m_instr);
        chk({tag, ".PCD"},      PCD,             m_pc);
        chk({tag, ".PC8D"},     PC8D,            m_pc8);
        chk({tag, ".ExcCodeD"}, {27'd0, ExcCodeD}, {27'd0, m_exc});
        chk({tag, ".BDD"},      {31'd0, BDD},    {31'd0, m_bd});
        chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, m_vld});
    endtask

    task automatic model_reset();
        m_instr = 32'h0;
        m_pc    = 32'h00003000;
        m_pc8   = 32'h00003008;
        m_exc   = 5'd0;
        m_bd    = 1'b0;
        m_vld   = 1'b0;
    endtask

    // What one rising edge does to the stage, given the inputs present at it.
    task automatic model_edge();
        if (Flush) begin
            m_instr = 32'h0;
            m_pc    = PCIn;
            m_pc8   = PCIn + 32'd8;
            m_exc   = 5'd0;
            m_bd    = 1'b0;
            m_vld   = 1'b0;
        end else if (!Stall) begin
            m_instr = (ExcCodeIn != 5'd0) ? 32'h0 : InstrIn;
            m_pc    = PCIn;
            m_pc8   = PCIn + 32'd8;
            m_exc   = ExcCodeIn;
            m_bd    = IsBranchD;
            m_vld   = 1'b1;
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge act, check on the next falling edge.
    task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [4:0] exc, input logic br);
        Stall     = st;
        Flush     = fl;
        PCIn      = pc;
        InstrIn   = ins;
        ExcCodeIn = exc;
        IsBranchD = br;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        Stall = 0; Flush = 0; PCIn = 0; InstrIn = 0; ExcCodeIn = 0; IsBranchD = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset_hold");
        reset = 1'b0;

        step("load_plain", 0, 0, 32'h00003000, 32'h3c010001, 5'd0, 1'b0);

        // Reset between edges must act at once.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 reset = 1'b0;
        @(negedge clk);

        step("load_branch", 0, 0, 32'h00003004, 32'h24010001, 5'd0, 1'b1);
        chk("vec_branch.InstrD", InstrD, 32'h24010001);
        chk("vec_branch.PC8D",   PC8D,   32'h0000300C);
        chk("vec_branch.BDD",    {31'd0, BDD}, 32'd1);

        step("load_adel", 0, 0, 32'h00003002, 32'hdeadbeef, 5'd4, 1'b0);
        chk("vec_adel.InstrD",   InstrD, 32'h0);
        chk("vec_adel.ExcCodeD", {27'd0, ExcCodeD}, 32'd4);

        step("pre_stall", 0, 0, 32'h00003010, 32'h8c220000, 5'd0, 1'b1);
        step("stall1", 1, 0, 32'h00003014, 32'h11111111, 5'd0, 1'b0);
        step("stall2", 1, 0, 32'h00003018, 32'h22222222, 5'd4, 1'b0);
        step("stall3", 1, 0, 32'h0000301c, 32'h33333333, 5'd0, 1'b1);
        chk("vec_stall.InstrD", InstrD, 32'h8c220000);
        step("stall_release", 0, 0, 32'h00003020, 32'h44444444, 5'd0, 1'b0);
        chk("vec_release.PCD", PCD, 32'h00003020);

        step("stall_flush", 1, 1, 32'h00003024, 32'h55555555, 5'd4, 1'b1);
        chk("vec_sflush.ValidD", {31'd0, ValidD}, 32'd0);
        chk("vec_sflush.PCD",    PCD, 32'h00003024);
        step("flush2", 0, 1, 32'h00003028, 32'h66666666, 5'd0, 1'b1);
        step("after_flush", 0, 0, 32'h0000302c, 32'h77777777, 5'd0, 1'b1);

        step("wrap", 0, 0, 32'hFFFFFFFC, 32'h01234567, 5'd0, 1'b0);
        chk("vec_wrap.PC8D", PC8D, 32'h00000004);

        // Reset during a stall overrides it; the next edge obeys Stall again.
        Stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid_stall");
        #1 reset = 1'b0;
        @(negedge clk);
        step("stall_after_reset", 1, 0, 32'h00004000, 32'h99999999, 5'd0, 1'b1);
        step("load_after_reset", 0, 0, 32'h00004004, 32'haaaaaaaa, 5'd0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic        st, fl, br;
            logic [4:0]  exc;
            logic [31:0] pc;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            br  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       exc = 5'd4;
                1:       exc = 5'($urandom);
                default: exc = 5'd0;
            endcase
            pc = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | (32'($urandom) & 32'hF))
                                              : 32'($urandom);
            step($sformatf("rand%0d", i), st, fl, pc, 32'($urandom), exc, br);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000: PCD value after reset and fetch base address.
REQ-002 Parameter NOP_INSTR, default 32'h00000000: instruction word injected as a bubble.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 Stall  input  1  high: hold all registered outputs (ID stage stalled by hazard unit).
REQ-006 Flush  input  1  high: replace the stage contents with a bubble (exception/eret redirect).
REQ-007 PCIn  input  32  address of the instruction currently being fetched (PC register output).
REQ-008 InstrIn  input  32  instruction word read from IM at PCIn.
REQ-009 ExcCodeIn  input  5  fetch exception code from the PC stage: 0 = none, 4 = AdEL.
REQ-010 IsBranchD  input  1  instruction currently held in ID is a branch/jump, so the next fetched instruction is its delay slot.
REQ-011 InstrD  output  32  instruction presented to the ID stage.
REQ-012 PCD  output  32  PC of InstrD.
REQ-013 PC8D  output  32  PCD + 8, the link address for jal/jalr.
REQ-014 ExcCodeD  output  5  exception code carried with InstrD.
REQ-015 BDD  output  1  InstrD is in a branch delay slot.
REQ-016 ValidD  output  1  InstrD is a real fetched instruction, not a bubble.

Function
REQ-017 Each rising edge SHALL perform exactly one action, chosen in priority order: Flush, then Stall, then Load.
REQ-018 Load (Stall=0, Flush=0): PCD<=PCIn; PC8D<=PCIn+8 mod 2^32; ExcCodeD<=ExcCodeIn; BDD<=IsBranchD; ValidD<=1.
REQ-019 Load with ExcCodeIn==0: InstrD<=InstrIn.
REQ-020 Load with ExcCodeIn!=0: InstrD<=NOP_INSTR, so the faulting word is never decoded; ExcCodeD, PCD and BDD still load so EPC and BD can be derived downstream.
REQ-021 Stall=1, Flush=0: every output SHALL hold its previous value, including BDD and ValidD.
REQ-022 Flush=1, regardless of Stall: InstrD<=NOP_INSTR, ExcCodeD<=0, BDD<=0, ValidD<=0, PCD<=PCIn, PC8D<=PCIn+8.
REQ-023 The block SHALL be a pure single-cycle pipeline register: every input that is loaded appears on the outputs in the cycle after the capturing edge, with no combinational input-to-output path.
REQ-024 BDD SHALL depend only on IsBranchD sampled at the capturing edge, never on InstrIn.
REQ-025 The PC8D add SHALL be 32-bit unsigned and wrap (PCIn=32'hFFFFFFFC gives PC8D=32'h00000004); the block performs no range checks of its own.
REQ-026 Back-to-back Flush cycles SHALL each produce a bubble; the first Load after a Flush captures normally.
REQ-027 A Stall lasting N cycles SHALL hold the outputs for exactly N cycles; the first edge with Stall=0 loads the current inputs.

Reset
REQ-028 While reset=1, independent of clk: InstrD=NOP_INSTR, PCD=RESET_PC, PC8D=RESET_PC+8, ExcCodeD=0, BDD=0, ValidD=0.
REQ-029 reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion performs a normal priority-ordered action.
REQ-030 There is no initial-value dependence; the reset state is the only defined power-up state.

Verification
REQ-031 Reset asserted between clock edges -> outputs change immediately to InstrD=0, PCD=32'h00003000, PC8D=32'h00003008, ValidD=0.
REQ-032 Load PCIn=32'h00003004, InstrIn=32'h24010001, IsBranchD=1 -> next cycle InstrD=32'h24010001, PCD=32'h00003004, PC8D=32'h0000300C, BDD=1, ValidD=1.
REQ-033 Load PCIn=32'h00003002, ExcCodeIn=4 -> InstrD=0, ExcCodeD=4, PCD=32'h00003002, ValidD=1.
REQ-034 Stall=1 for 3 cycles while the inputs change every cycle -> outputs constant for 3 cycles; on the 4th edge they equal the inputs present at that edge.
REQ-035 Stall=1 and Flush=1 together with ExcCodeIn=4 -> InstrD=0, ExcCodeD=0, BDD=0, ValidD=0, PCD=PCIn.
REQ-036 PCIn=32'hFFFFFFFC loaded -> PC8D=32'h00000004.
